// File: rtl/stream_fifo_pkg.sv
// Shared types and helpers for stream_fifo: level width, occupancy state, stats width.
package stream_fifo_pkg;

  localparam int unsigned STAT_CNT_W = 32;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// 1-write/1-read register array with combinational read port.
module stream_fifo_mem #(
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_DEPTH      = 8
) (
  input  logic                       i_clk,
  input  logic                       i_we,
  input  logic [$clog2(P_DEPTH)-1:0] i_waddr,
  input  logic [P_DATA_WIDTH-1:0]    i_wdata,
  input  logic [$clog2(P_DEPTH)-1:0] i_raddr,
  output logic [P_DATA_WIDTH-1:0]    o_rdata
);

  logic [P_DATA_WIDTH-1:0] r_mem [P_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready stream FIFO with registered occupancy flags.
// Optional statistics outputs when STREAM_FIFO_STAT_EN is defined.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH  = 32,
  parameter int unsigned P_DEPTH       = 8,
  parameter int unsigned P_AFULL_LEVEL = 6
) (
  input  logic                                I_CLK,
  input  logic                                I_RESET,
  input  logic                                I_S_VALID,
  output logic                                O_S_READY,
  input  logic [P_DATA_WIDTH-1:0]             I_S_DATA,
  output logic                                O_M_VALID,
  input  logic                                I_M_READY,
  output logic [P_DATA_WIDTH-1:0]             O_M_DATA,
  output logic [level_width(P_DEPTH)-1:0]     O_LEVEL,
  output logic                                O_EMPTY,
  output logic                                O_FULL,
  output logic                                O_AFULL
`ifdef STREAM_FIFO_STAT_EN
  ,
  output logic [STAT_CNT_W-1:0]               O_PUSH_CNT,
  output logic [level_width(P_DEPTH)-1:0]     O_MAX_LEVEL
`endif
);

  localparam int unsigned AW = $clog2(P_DEPTH);
  localparam int unsigned LW = level_width(P_DEPTH);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [LW-1:0] w_level_nxt;
  logic          r_afull;
  occ_state_t    r_occ;
  occ_state_t    w_occ_nxt;
  logic          w_push;
  logic          w_pop;

  assign O_EMPTY   = (r_occ == OCC_EMPTY);
  assign O_FULL    = (r_occ == OCC_FULL);
  assign O_AFULL   = r_afull;
  assign O_LEVEL   = r_level;
  assign O_S_READY = !O_FULL && !I_RESET;
  assign O_M_VALID = !O_EMPTY;

  assign w_push = I_S_VALID && O_S_READY;
  assign w_pop  = O_M_VALID && I_M_READY;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + LW'(1);
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - LW'(1);
    end
  end

  always_comb begin
    w_occ_nxt = r_occ;
    case (r_occ)
      OCC_EMPTY:   if (w_push) w_occ_nxt = OCC_PARTIAL;
      OCC_PARTIAL: begin
        if (w_push && !w_pop && w_level_nxt == LW'(P_DEPTH)) begin
          w_occ_nxt = OCC_FULL;
        end else if (w_pop && !w_push && w_level_nxt == '0) begin
          w_occ_nxt = OCC_EMPTY;
        end
      end
      OCC_FULL:    if (w_pop) w_occ_nxt = OCC_PARTIAL;
      default:     w_occ_nxt = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_occ   <= OCC_EMPTY;
      r_afull <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_level <= w_level_nxt;
      r_occ   <= w_occ_nxt;
      r_afull <= (w_level_nxt >= LW'(P_AFULL_LEVEL));
    end
  end

`ifdef STREAM_FIFO_STAT_EN
  logic [STAT_CNT_W-1:0] r_push_cnt;
  logic [LW-1:0]         r_max_level;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_push_cnt  <= '0;
      r_max_level <= '0;
    end else begin
      if (w_push) r_push_cnt <= r_push_cnt + STAT_CNT_W'(1);
      if (w_level_nxt > r_max_level) r_max_level <= w_level_nxt;
    end
  end

  assign O_PUSH_CNT  = r_push_cnt;
  assign O_MAX_LEVEL = r_max_level;
`endif

  stream_fifo_mem #(
    .P_DATA_WIDTH (P_DATA_WIDTH),
    .P_DEPTH      (P_DEPTH)
  ) u_mem (
    .i_clk   (I_CLK),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (I_S_DATA),
    .i_raddr (r_rptr),
    .o_rdata (O_M_DATA)
  );

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: table vectors, corner sequences, random vs queue model.
module tb_stream_fifo;

  localparam int DEPTH = 8;
  localparam int AFULL = 6;

  logic        I_CLK = 1'b0;
  logic        I_RESET;
  logic        I_S_VALID;
  logic        O_S_READY;
  logic [31:0] I_S_DATA;
  logic        O_M_VALID;
  logic        I_M_READY;
  logic [31:0] O_M_DATA;
  logic [3:0]  O_LEVEL;
  logic        O_EMPTY;
  logic        O_FULL;
  logic        O_AFULL;
`ifdef STREAM_FIFO_STAT_EN
  logic [31:0] O_PUSH_CNT;
  logic [3:0]  O_MAX_LEVEL;
`endif

  always #5 I_CLK = ~I_CLK;

  stream_fifo #(
    .P_DATA_WIDTH  (32),
    .P_DEPTH       (DEPTH),
    .P_AFULL_LEVEL (AFULL)
  ) dut (
    .I_CLK     (I_CLK),
    .I_RESET   (I_RESET),
    .I_S_VALID (I_S_VALID),
    .O_S_READY (O_S_READY),
    .I_S_DATA  (I_S_DATA),
    .O_M_VALID (O_M_VALID),
    .I_M_READY (I_M_READY),
    .O_M_DATA  (O_M_DATA),
    .O_LEVEL   (O_LEVEL),
    .O_EMPTY   (O_EMPTY),
    .O_FULL    (O_FULL),
    .O_AFULL   (O_AFULL)
`ifdef STREAM_FIFO_STAT_EN
    ,
    .O_PUSH_CNT  (O_PUSH_CNT),
    .O_MAX_LEVEL (O_MAX_LEVEL)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: plain queue of accepted words plus stats.
  logic [31:0] q[$];
  int          m_cnt = 0;
  int          m_max = 0;

  typedef struct {
    logic        sv;
    logic [31:0] d;
    logic        mr;
    int          lvl;
    logic        full;
    logic [31:0] head;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_state();
    chk("level", O_LEVEL, q.size());
    chk("empty", O_EMPTY, q.size() == 0);
    chk("full",  O_FULL,  q.size() == DEPTH);
    chk("afull", O_AFULL, q.size() >= AFULL);
    chk("m_valid", O_M_VALID, q.size() > 0);
    if (q.size() > 0) chk("m_data", O_M_DATA, q[0]);
`ifdef STREAM_FIFO_STAT_EN
    chk("push_cnt", O_PUSH_CNT, m_cnt);
    chk("max_level", O_MAX_LEVEL, m_max);
`endif
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] d,
                       input logic m, output logic acc);
    logic e_push, e_pop;
    I_RESET   = r;
    I_S_VALID = v;
    I_S_DATA  = d;
    I_M_READY = m;
    #1;
    chk("s_ready", O_S_READY, (q.size() < DEPTH) && !r);
    e_push = v && (q.size() < DEPTH) && !r;
    e_pop  = m && (q.size() > 0) && !r;
    @(posedge I_CLK);
    if (r) begin
      q.delete();
      m_cnt = 0;
      m_max = 0;
    end else begin
      if (e_pop) void'(q.pop_front());
      if (e_push) begin
        q.push_back(d);
        m_cnt++;
      end
      if (q.size() > m_max) m_max = q.size();
    end
    #1;
    check_state();
    acc = e_push;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic        cur_v;
    logic [31:0] cur_d;

    for (int i = 1; i <= 8; i++)
      tbl[i-1] = '{1'b1, 32'(i * 'h11), 1'b0, i, (i == 8), 32'h11};
    tbl[8] = '{1'b1, 32'h99, 1'b0, 8, 1'b1, 32'h11};
    for (int k = 1; k <= 8; k++)
      tbl[8+k] = '{1'b0, 32'h0, 1'b1, 8 - k, 1'b0, 32'((k + 1) * 'h11)};

    I_RESET = 1'b1; I_S_VALID = 1'b0; I_S_DATA = '0; I_M_READY = 1'b0;
    repeat (2) @(posedge I_CLK);
    #1;
    chk("ready_in_reset", O_S_READY, 1'b0);
    check_state();

    // Fill past full, then drain in order.
    foreach (tbl[i]) begin
      drive(1'b0, tbl[i].sv, tbl[i].d, tbl[i].mr, acc);
      chk("tbl_level", O_LEVEL, tbl[i].lvl);
      chk("tbl_full", O_FULL, tbl[i].full);
      if (tbl[i].lvl > 0) chk("tbl_head", O_M_DATA, tbl[i].head);
      else chk("tbl_mvalid", O_M_VALID, 1'b0);
    end

    // Streaming with both sides ready: level stays at 1.
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 32'h1000 + i, 1'b1, acc);
      chk("stream_level", O_LEVEL, 1);
      chk("stream_head", O_M_DATA, 32'h1000 + i);
    end
    drive(1'b0, 1'b0, 0, 1'b1, acc);
    chk("stream_drained", O_EMPTY, 1'b1);

    // Almost-full boundary.
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 32'h200 + i, 1'b0, acc);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 32'h300 + i, 1'b1, acc);
      chk("af5_level", O_LEVEL, 5);
      chk("af5_afull", O_AFULL, 1'b0);
    end
    drive(1'b0, 1'b1, 32'h400, 1'b0, acc);
    chk("af6_afull", O_AFULL, 1'b1);
    repeat (6) drive(1'b0, 1'b0, 0, 1'b1, acc);

    // Mid-operation reset at level 4.
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 32'h500 + i, 1'b0, acc);
    chk("pre_rst_level", O_LEVEL, 4);
    drive(1'b1, 1'b0, 0, 1'b0, acc);
    chk("rst_level", O_LEVEL, 0);
    chk("rst_mvalid", O_M_VALID, 1'b0);
    drive(1'b0, 1'b1, 32'hAB, 1'b0, acc);
    chk("post_rst_head", O_M_DATA, 32'hAB);
    drive(1'b0, 1'b0, 0, 1'b1, acc);

    // Random traffic; upstream holds a word until it is accepted.
    cur_v = 1'b0;
    cur_d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!cur_v) begin
        cur_v = ($urandom_range(0, 3) != 0);
        cur_d = $urandom;
      end
      drive(($urandom_range(0, 99) == 0), cur_v, cur_d,
            ($urandom_range(0, 2) == 0), acc);
      if (acc || I_RESET) cur_v = 1'b0;
    end
    drive(1'b1, 1'b0, 0, 1'b0, acc);

`ifdef STREAM_FIFO_STAT_EN
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 32'h700 + i, 1'b0, acc);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 0, 1'b1, acc);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 32'h800 + i, 1'b0, acc);
    chk("stat_cnt10", O_PUSH_CNT, 10);
    chk("stat_max7", O_MAX_LEVEL, 7);
    drive(1'b1, 1'b0, 0, 1'b0, acc);
    chk("stat_cnt_rst", O_PUSH_CNT, 0);
    chk("stat_max_rst", O_MAX_LEVEL, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
# stream_fifo

Synchronous valid/ready stream FIFO sitting directly downstream of a DUT output port, buffering its data stream before the bench monitor or the next RTL stage consumes it. It absorbs back-pressure bursts up to `P_DEPTH` words, exposes occupancy and threshold flags to the monitor, and guarantees no loss, duplication or reordering of words.

## Interface
- `P_DATA_WIDTH`, 32: payload width in bits, ≥1.
- `P_DEPTH`, 8: storage depth in words; power of two, ≥2.
- `P_AFULL_LEVEL`, 6: almost-full threshold, 1..`P_DEPTH`.

Ports (clock and reset first):
- `I_CLK` in 1: single clock, all logic on rising edge.
- `I_RESET` in 1: reset; synchronous, active-high.
- `I_S_VALID` in 1: upstream word valid.
- `O_S_READY` out 1: FIFO can accept a word.
- `I_S_DATA` in `P_DATA_WIDTH`: upstream payload.
- `O_M_VALID` out 1: head word valid.
- `I_M_READY` in 1: downstream accepts head word.
- `O_M_DATA` out `P_DATA_WIDTH`: head word payload.
- `O_LEVEL` out `$clog2(P_DEPTH)+1`: current occupancy, 0..`P_DEPTH`.
- `O_EMPTY` out 1: `O_LEVEL == 0`.
- `O_FULL` out 1: `O_LEVEL == P_DEPTH`.
- `O_AFULL` out 1: `O_LEVEL >= P_AFULL_LEVEL`.
- Only with `STREAM_FIFO_STAT_EN`:
  - `O_PUSH_CNT` out 32: words accepted since reset.
  - `O_MAX_LEVEL` out `$clog2(P_DEPTH)+1`: high-water mark since reset.

## Operation
- Push when `I_S_VALID && O_S_READY`; pop when `O_M_VALID && I_M_READY`. Data is captured only on push.
- `O_S_READY = !O_FULL && !I_RESET`. A full FIFO refuses a push even if a pop happens in the same cycle; no combinational ready→ready path.
- `O_M_VALID = !O_EMPTY`. `O_M_DATA` is the word at the read pointer. Value is don't-care while `O_M_VALID` is 0; the bench checks it only when valid.
- Occupancy state, derived from the count:
  - EMPTY: push only → PARTIAL.
  - PARTIAL: push only → +1, becomes FULL at `P_DEPTH`. Pop only → −1, becomes EMPTY at 0. Push and pop together → level unchanged.
  - FULL: pop only → PARTIAL.
- Pointers are `$clog2(P_DEPTH)` bits and wrap modulo `P_DEPTH` naturally. The level counter is one bit wider. Level never exceeds `P_DEPTH` and never underflows.
- Upstream must hold `I_S_VALID` and `I_S_DATA` stable until accepted. The FIFO holds `O_M_VALID` and `O_M_DATA` stable until popped.

## Timing
- Write-to-read latency: a word pushed at edge N is visible on `O_M_VALID`/`O_M_DATA` after edge N (cycle N+1). There is no same-cycle bypass.
- `O_LEVEL`, `O_EMPTY`, `O_FULL` and `O_AFULL` are registered and update on the edge following the push or pop.
- Reset, including mid-operation: on any edge with `I_RESET`=1, pointers, level and stats clear. Stored contents are discarded.
- Output values during and after reset:
  - During reset: `O_S_READY`=0.
  - After reset: `O_M_VALID`=0, `O_LEVEL`=0, `O_EMPTY`=1, `O_FULL`=0, `O_AFULL`=0, `O_PUSH_CNT`=0, `O_MAX_LEVEL`=0.
  - `O_S_READY`=1 from the first cycle after `I_RESET` falls.

## Configuration
- `STREAM_FIFO_STAT_EN` defined:
  - `O_PUSH_CNT` increments on every push and wraps at 2^32.
  - `O_MAX_LEVEL` updates to the next-cycle level whenever that level exceeds it.
  - Both clear on reset.
- Undefined: the ports and logic are absent, and FIFO behaviour is otherwise identical.

## Structure
- `stream_fifo_pkg` holds:
  - A level-width function (`$clog2(depth)+1`).
  - An occupancy-state enum (EMPTY/PARTIAL/FULL) used by the monitor for coverage.
  - The stats counter width constant (32).
- Sub-module `stream_fifo_mem` is the storage: a 1-write/1-read register array with write enable, write address, read address and combinational read data. `stream_fifo` owns the pointers, level, flags and stats.

## Test plan
- Reset, then 8 pushes (0x11..0x88) with `I_M_READY`=0 → `O_FULL`=1, `O_LEVEL`=8, `O_S_READY`=0. A 9th word held on `I_S_DATA` is not accepted.
- From that full state, `I_M_READY`=1 for 8 cycles → output sequence 0x11..0x88 in order, then `O_EMPTY`=1 and `O_M_VALID`=0.
- Continuous push and pop with both sides always ready, 20 words → `O_LEVEL` stays at 1, one-cycle latency. Pointer wrap is exercised with no loss or reordering.
- Fill to 5, then simultaneous push and pop for 4 cycles → `O_LEVEL` stays 5 and `O_AFULL`=0. Fill to 6 → `O_AFULL`=1 on the next cycle.
- Assert `I_RESET` for 1 cycle at level 4 → next cycle `O_LEVEL`=0 and `O_M_VALID`=0. A new push of 0xAB emerges as the first word.
- With `STREAM_FIFO_STAT_EN`: push 10 words with peak level 7 → `O_PUSH_CNT`=10 and `O_MAX_LEVEL`=7. After reset, both read 0.
